// File: rtl/sha256_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sha256_rr_arbiter                                                |
// | Brief    : Round-robin sequencer sharing one SHA-256 core among requesters. |
// |            Optional watchdog in WAIT enabled by macro ARB_TIMEOUT_EN.       |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module sha256_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*512-1:0]   req_block,
  input  logic [NUM_REQ*256-1:0]   req_state,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       req_done,
`ifdef ARB_TIMEOUT_EN
  output logic [NUM_REQ-1:0]       req_err,
`endif
  output logic [255:0]             result,
  output logic                     core_start,
  output logic [511:0]             core_block,
  output logic [255:0]             core_state,
  input  logic                     core_done,
  input  logic [255:0]             core_hash,
  output logic                     busy
);

  localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("sha256_rr_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               r_fsm;
  logic [c_ptr_w-1:0]   r_ptr;
  logic [c_ptr_w-1:0]   r_idx;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic [255:0]         r_result;
  logic                 r_start;
  logic [511:0]         r_core_block;
  logic [255:0]         r_core_state;
  logic                 r_busy;

  logic                 w_found;
  logic [c_ptr_w-1:0]   w_sel_idx;
  logic [NUM_REQ-1:0]   w_sel_onehot;

  // Modular add on the requester index, wrapping at NUM_REQ.
  function automatic logic [c_ptr_w-1:0] wrap_add(input logic [c_ptr_w-1:0] base,
                                                  input int unsigned        off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_REQ)) sum = sum - 32'(NUM_REQ);
    return sum[c_ptr_w-1:0];
  endfunction

  // First asserted request at or after the round-robin pointer.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[wrap_add(r_ptr, i)]) begin
        w_found   = 1'b1;
        w_sel_idx = wrap_add(r_ptr, i);
      end
    end
  end

  assign w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;

  logic [c_cnt_w-1:0]   r_cnt;
  logic [NUM_REQ-1:0]   r_err;

  assign req_err = r_err;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_fsm        <= ST_IDLE;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_result     <= '0;
      r_start      <= 1'b0;
      r_core_block <= '0;
      r_core_state <= '0;
      r_busy       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_err        <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
`ifdef ARB_TIMEOUT_EN
      r_err   <= '0;
`endif
      case (r_fsm)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt        <= w_sel_onehot;
            r_idx        <= w_sel_idx;
            r_core_block <= req_block[512*w_sel_idx +: 512];
            r_core_state <= req_state[256*w_sel_idx +: 256];
            r_busy       <= 1'b1;
            r_fsm        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_start <= 1'b1;
`ifdef ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_fsm   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            r_result <= core_hash;
            r_done   <= r_gnt;
            r_gnt    <= '0;
            r_fsm    <= ST_RESP;
          end
`ifdef ARB_TIMEOUT_EN
          // Watchdog expiry completes the transaction with result left untouched.
          else if (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
            r_done <= r_gnt;
            r_err  <= r_gnt;
            r_gnt  <= '0;
            r_fsm  <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          r_ptr  <= wrap_add(r_idx, 1);
          r_busy <= 1'b0;
          r_fsm  <= ST_IDLE;
        end
        default: begin
          r_fsm <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign req_done   = r_done;
  assign result     = r_result;
  assign core_start = r_start;
  assign core_block = r_core_block;
  assign core_state = r_core_state;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sha256_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_sha256_rr_arbiter                                             |
// | Brief    : Directed scoreboard bench for sha256_rr_arbiter with core model. |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_sha256_rr_arbiter;

  localparam int NR = 4;

  typedef struct {
    logic [NR-1:0] done;
    logic [255:0]  hash;
    logic [NR-1:0] err;
  } exp_t;

  logic               clk = 1'b0;
  logic               n_rst;
  logic [NR-1:0]      req;
  logic [NR*512-1:0]  req_block;
  logic [NR*256-1:0]  req_state;
  logic [NR-1:0]      gnt;
  logic [NR-1:0]      req_done;
`ifdef ARB_TIMEOUT_EN
  logic [NR-1:0]      req_err;
`endif
  logic [255:0]       result;
  logic               core_start;
  logic [511:0]       core_block;
  logic [255:0]       core_state;
  logic               core_done;
  logic [255:0]       core_hash;
  logic               busy;

  int   vectors = 0;
  int   errors  = 0;
  exp_t sb[$];

  logic         core_enable;
  int           core_lat;
  logic         fixed_en;
  logic [255:0] fixed_hash;

  always #5 clk = ~clk;

  sha256_rr_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req        (req),
    .req_block  (req_block),
    .req_state  (req_state),
    .gnt        (gnt),
    .req_done   (req_done),
`ifdef ARB_TIMEOUT_EN
    .req_err    (req_err),
`endif
    .result     (result),
    .core_start (core_start),
    .core_block (core_block),
    .core_state (core_state),
    .core_done  (core_done),
    .core_hash  (core_hash),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_hash(input int i);
    return req_state[256*i +: 256] ^ req_block[512*i+256 +: 256];
  endfunction

  // Core model: digest arrives core_lat cycles after the start pulse.
  initial begin
    core_done = 1'b0;
    core_hash = '0;
    forever begin
      @(posedge clk); #1;
      if (core_start && core_enable) begin
        repeat (core_lat) @(posedge clk);
        #1;
        core_done = 1'b1;
        core_hash = fixed_en ? fixed_hash : (core_state ^ core_block[511:256]);
        @(posedge clk); #1;
        core_done = 1'b0;
        core_hash = '0;
      end
    end
  end

  // Monitor: grant exclusivity every cycle, scoreboard check on every completion.
  initial begin
    logic [NR-1:0] last_gnt;
    exp_t          e;
    last_gnt = '0;
    forever begin
      @(negedge clk);
      check("gnt_onehot", 512'($countones(gnt) <= 1), 512'(1));
      if (gnt != '0) last_gnt = gnt;
      if (req_done != '0) begin
        check("done_vs_gnt", 512'(req_done), 512'(last_gnt));
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $error("FAIL sb_underflow observed=%0h expected=none", req_done);
        end else begin
          e = sb.pop_front();
          check("done_idx", 512'(req_done), 512'(e.done));
          check("result", 512'(result), 512'(e.hash));
`ifdef ARB_TIMEOUT_EN
          check("err_idx", 512'(req_err), 512'(e.err));
`endif
        end
      end
    end
  end

  task automatic wait_start(input string tag);
    int c;
    c = 0;
    @(negedge clk);
    while (!core_start && c < 200) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_start_seen"}, 512'(core_start), 512'(1));
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    @(negedge clk);
    while (req_done == '0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done_seen"}, 512'(req_done != '0), 512'(1));
  endtask

  initial begin
    logic [511:0] saved_blk;
    logic [255:0] last_exp;
    int           done_cnt;
    int           n;

    n_rst       = 1'b0;
    req         = 4'b1111;
    core_enable = 1'b1;
    core_lat    = 3;
    fixed_en    = 1'b0;
    fixed_hash  = {32{8'hA5}};
    for (int i = 0; i < NR; i++) begin
      for (int w = 0; w < 16; w++) req_block[512*i + 32*w +: 32] = $urandom();
      for (int w = 0; w < 8; w++)  req_state[256*i + 32*w +: 32] = $urandom();
    end

    // Reset with all requests held.
    repeat (3) @(negedge clk);
    check("rst_gnt", 512'(gnt), 512'(0));
    check("rst_req_done", 512'(req_done), 512'(0));
    check("rst_core_start", 512'(core_start), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_result", 512'(result), 512'(0));
    check("rst_core_block", core_block, 512'(0));
    check("rst_core_state", 512'(core_state), 512'(0));
`ifdef ARB_TIMEOUT_EN
    check("rst_req_err", 512'(req_err), 512'(0));
`endif

    // Twelve services with all four requesting: order 0,1,2,3 repeating.
    for (int k = 0; k < 12; k++)
      sb.push_back('{done: 4'(1 << (k % NR)), hash: exp_hash(k % NR), err: 4'b0000});
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("first_gnt", 512'(gnt), 512'(4'b0001));
    check("first_start_low", 512'(core_start), 512'(0));
    check("first_busy", 512'(busy), 512'(1));
    @(posedge clk); #1;
    check("first_start", 512'(core_start), 512'(1));
    done_cnt = 0;
    for (int c = 0; c < 2000 && done_cnt < 12; c++) begin
      @(negedge clk);
      if (req_done != '0) begin
        done_cnt++;
        if (done_cnt == 12) req = 4'b0000;
      end
    end
    check("rr_services", 512'(done_cnt), 512'(12));

    // Single request with fixed digest and long core latency.
    core_lat = 64;
    fixed_en = 1'b1;
    sb.push_back('{done: 4'b0100, hash: fixed_hash, err: 4'b0000});
    req = 4'b0100;
    wait_start("single");
    check("single_core_block", core_block, 512'(req_block[1535:1024]));
    check("single_core_state", 512'(core_state), 512'(req_state[767:512]));
    wait_done("single");
    req = 4'b0000;
    @(negedge clk);
    check("single_pulse_width", 512'(req_done), 512'(0));
    check("single_result_hold", 512'(result), 512'(fixed_hash));
    fixed_en = 1'b0;

    // Requester 2 alters its block and drops req while the core is busy.
    core_lat  = 10;
    saved_blk = req_block[1535:1024];
    last_exp  = exp_hash(2);
    sb.push_back('{done: 4'b0100, hash: last_exp, err: 4'b0000});
    req = 4'b0100;
    wait_start("drop");
    req_block[1535:1024] = ~saved_blk;
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check("drop_core_block", core_block, saved_blk);
    wait_done("drop");

    // Asynchronous reset while waiting on the core.
    core_enable = 1'b0;
    req = 4'b0001;
    wait_start("abort");
    n_rst = 1'b0;
    #1;
    check("abort_gnt", 512'(gnt), 512'(0));
    check("abort_busy", 512'(busy), 512'(0));
    check("abort_core_start", 512'(core_start), 512'(0));
    req         = 4'b1000;
    core_enable = 1'b1;
    core_lat    = 5;
    last_exp    = exp_hash(3);
    sb.push_back('{done: 4'b1000, hash: last_exp, err: 4'b0000});
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_gnt", 512'(gnt), 512'(4'b1000));
    wait_done("post_rst");
    req = 4'b0000;

`ifdef ARB_TIMEOUT_EN
    // Core never answers: watchdog completes with error, result unchanged.
    core_enable = 1'b0;
    sb.push_back('{done: 4'b0010, hash: last_exp, err: 4'b0010});
    req = 4'b0010;
    wait_start("timeout");
    n = 0;
    while (req_done == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 512'(n), 512'(16));
    check("timeout_err", 512'(req_err), 512'(4'b0010));
    req = 4'b0000;
    core_enable = 1'b1;
`else
    n = 0;
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", 512'(sb.size()), 512'(0));
    check("final_busy", 512'(busy), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
